rv_multicycle: RTL
==================

RV_MULTICYCLE -- requirements
Module: rv_multicycle

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the datapath, register and address width in bits.
REQ-002 The block SHALL have parameter NREGS, default 32, giving the architectural register count (16 or 32 only).
REQ-003 The block SHALL have parameter RESET_PC, default 0, giving the first fetch address after reset.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port mem_req, output, 1 bit: memory transaction request.
REQ-007 The block SHALL have port mem_we, output, 1 bit: 1 = write, 0 = read; valid only while mem_req is high.
REQ-008 The block SHALL have port mem_addr, output, WIDTH bits: byte address of the transaction.
REQ-009 The block SHALL have port mem_wdata, output, WIDTH bits: store data.
REQ-010 The block SHALL have port mem_rdata, input, WIDTH bits: read data, sampled in the mem_ready cycle.
REQ-011 The block SHALL have port mem_ready, input, 1 bit: transaction completes in any cycle where mem_req and mem_ready are both high.
REQ-012 The block SHALL have port a0, output, WIDTH bits: continuous copy of register x10.
REQ-013 The block SHALL have port halted, output, 1 bit: high while in state HALT.

Function
REQ-014 The supported instructions SHALL be ADD, ADDI, BEQ, BNE, LW and SW (RV32I encodings); any other opcode/funct3/funct7, or any register index >= NREGS, SHALL be illegal.
REQ-015 The FSM states SHALL be FETCH, DECODE, EXEC, MEM, WB and HALT.
REQ-016 FETCH: mem_req=1, mem_we=0, mem_addr=PC; on mem_ready, latch mem_rdata into IR and go to DECODE; otherwise stay.
REQ-017 DECODE: latch rs1/rs2 operands and the sign-extended immediate (I, S or B format); go to HALT if illegal, else EXEC.
REQ-018 EXEC: ADD/ADDI compute the sum and go to WB; LW/SW compute rs1+imm and go to MEM; BEQ/BNE set PC to PC+imm if taken, else PC+4, and go to FETCH.
REQ-019 MEM: mem_req=1, mem_addr=computed address, mem_we=1 with mem_wdata=rs2 for SW; on mem_ready, SW sets PC+4 and goes to FETCH, LW latches mem_rdata and goes to WB.
REQ-020 WB: write the result to rd unless rd=0, set PC+4, go to FETCH.
REQ-021 HALT SHALL be absorbing until reset, with mem_req=0 and no register or PC change.
REQ-022 mem_req, mem_we, mem_addr and mem_wdata SHALL be held stable from assertion until the completing mem_ready cycle; mem_ready while mem_req=0 SHALL be ignored.
REQ-023 With zero-wait memory, cycles per instruction SHALL be: branch 3, ADD/ADDI/SW 4, LW 5; each wait cycle SHALL add exactly one cycle.
REQ-024 x0 SHALL read as 0 at all times; writes to it SHALL be discarded.
REQ-025 All arithmetic SHALL be modulo 2^WIDTH; PC+4 and PC+imm SHALL wrap with no fault.
REQ-026 Address alignment SHALL NOT be checked; mem_addr SHALL be driven unmodified.

Reset
REQ-027 While rst is high: state=FETCH, PC=RESET_PC, IR=0, all registers=0, mem_req=0, mem_we=0, halted=0, a0=0.
REQ-028 Reset asserted mid-transaction SHALL drop mem_req asynchronously and abandon the transaction without any register write.
REQ-029 The first mem_req SHALL be asserted in the first rising edge cycle after rst deasserts.

Configuration
REQ-030 With macro RETIRE_CNT_EN defined, the block SHALL add output instret (64 bits), reset to 0 and incremented by 1 on each completed instruction (branch EXEC exit, SW MEM exit, WB exit).
REQ-031 Without RETIRE_CNT_EN, the instret port and counter SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-032 ADDI x10,x0,5 then ADD x10,x10,x10 with zero-wait memory -> a0=5 after 4 cycles, then a0=10 after 8 cycles.
REQ-033 SW x10,8(x0) with a0=10, memory inserting 3 wait cycles -> one write, mem_addr=8, mem_wdata=10, all outputs stable for 4 cycles, SW completes in 7 cycles.
REQ-034 BNE x10,x0,-4 at PC=0x10 with a0!=0 -> next fetch address 0x0C after 3 cycles; with a0=0 -> next fetch address 0x14.
REQ-035 ADDI x0,x0,7 then LW x10,0(x0) returning 0x1234 -> x0 stays 0, a0=0x1234 after 5 more cycles.
REQ-036 Illegal word 0xFFFFFFFF -> halted=1 two cycles after fetch completes, mem_req stays 0; assert rst -> halted=0 and fetch from RESET_PC.
REQ-037 With RETIRE_CNT_EN, run the REQ-032 sequence -> instret=2; rst mid-FETCH -> instret=0 and mem_req=0 immediately.

Source files
------------

// File: rtl/rv_multicycle.sv
// ---------------------------------------------------------------------------
// rv_multicycle
//   Multi-cycle RV32I subset core (ADD, ADDI, BEQ, BNE, LW, SW) with a single
//   shared instruction/data memory port and a simple req/ready handshake.
//   Any unsupported encoding, or a register index >= NREGS, parks the core
//   in HALT until reset.
//
// Parameters
//   WIDTH    : datapath/register/address width (32 or wider; IR is 32 bits)
//   NREGS    : architectural register count, 16 or 32
//   RESET_PC : first fetch address after reset
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst        : asynchronous active-high reset
//   mem_req    : memory transaction request
//   mem_we     : 1 = write, 0 = read (meaningful only while mem_req = 1)
//   mem_addr   : byte address, driven unmodified (no alignment check)
//   mem_wdata  : store data
//   mem_rdata  : read data, sampled in the cycle mem_ready is high
//   mem_ready  : completes the transaction when high together with mem_req
//   a0         : continuous copy of x10
//   halted     : high while in HALT
//   instret    : 64-bit retired-instruction counter (only with RETIRE_CNT_EN)
//
// Configuration
//   `define RETIRE_CNT_EN to add the instret output and its counter.
//
// States
//   FETCH  | request instruction at PC, latch into IR on ready
//   DECODE | latch operands and immediate, trap illegal encodings
//   EXEC   | ALU / address add, resolve branches
//   MEM    | LW/SW data transaction
//   WB     | register write-back, PC += 4
//   HALT   | absorbing until reset, no memory traffic
// ---------------------------------------------------------------------------
module rv_multicycle #(
    parameter int               WIDTH    = 32,
    parameter int               NREGS    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ready,
    output logic [WIDTH-1:0] a0,
    output logic             halted
`ifdef RETIRE_CNT_EN
    ,
    output logic [63:0]      instret
`endif
);

    localparam int RIW = $clog2(NREGS);

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALT
    } state_t;

    state_t state, state_nxt;

    logic [31:0]      ir;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] imm;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] regs [NREGS];

    // -----------------------------------------------------------------------
    // Instruction decode (IR is stable from DECODE until the next FETCH)
    // -----------------------------------------------------------------------
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd_f, rs1_f, rs2_f;

    assign opcode = ir[6:0];
    assign rd_f   = ir[11:7];
    assign funct3 = ir[14:12];
    assign rs1_f  = ir[19:15];
    assign rs2_f  = ir[24:20];
    assign funct7 = ir[31:25];

    logic is_add, is_addi, is_beq, is_bne, is_lw, is_sw;
    logic is_branch, uses_rd, uses_rs2;
    logic rd_ok, rs1_ok, rs2_ok, legal;

    assign is_add  = (opcode == 7'b0110011) && (funct3 == 3'b000) && (funct7 == 7'b0000000);
    assign is_addi = (opcode == 7'b0010011) && (funct3 == 3'b000);
    assign is_beq  = (opcode == 7'b1100011) && (funct3 == 3'b000);
    assign is_bne  = (opcode == 7'b1100011) && (funct3 == 3'b001);
    assign is_lw   = (opcode == 7'b0000011) && (funct3 == 3'b010);
    assign is_sw   = (opcode == 7'b0100011) && (funct3 == 3'b010);

    assign is_branch = is_beq | is_bne;
    assign uses_rd   = is_add | is_addi | is_lw;
    assign uses_rs2  = is_add | is_branch | is_sw;

    // With 16 registers, index bit 4 set means an out-of-range register.
    // Only the fields the instruction actually uses are checked.
    assign rs1_ok = (NREGS == 32) || !rs1_f[4];
    assign rs2_ok = (NREGS == 32) || !uses_rs2 || !rs2_f[4];
    assign rd_ok  = (NREGS == 32) || !uses_rd  || !rd_f[4];

    assign legal = (is_add | is_addi | is_branch | is_lw | is_sw) && rs1_ok && rs2_ok && rd_ok;

    logic [RIW-1:0] rd_i, rs1_i, rs2_i;

    assign rd_i  = rd_f[RIW-1:0];
    assign rs1_i = rs1_f[RIW-1:0];
    assign rs2_i = rs2_f[RIW-1:0];

    logic [WIDTH-1:0] imm_i, imm_s, imm_b, imm_sel;

    assign imm_i = {{(WIDTH-12){ir[31]}}, ir[31:20]};
    assign imm_s = {{(WIDTH-12){ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_b = {{(WIDTH-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};

    always_comb begin
        imm_sel = imm_i;
        if (is_sw) begin
            imm_sel = imm_s;
        end else if (is_branch) begin
            imm_sel = imm_b;
        end
    end

    logic [WIDTH-1:0] rs1_val, rs2_val;

    assign rs1_val = (rs1_i == '0) ? '0 : regs[rs1_i];
    assign rs2_val = (rs2_i == '0) ? '0 : regs[rs2_i];

    logic taken;

    assign taken = is_beq ? (op_a == op_b) : (op_a != op_b);

    // -----------------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // FSM next state and memory port
    //   The port is driven purely from state and registers that do not
    //   change while a transaction waits, so it holds stable until ready.
    //   rst gates mem_req/mem_we directly so an in-flight transaction is
    //   dropped the moment reset rises, not at the next edge.
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = pc;
        mem_wdata = op_b;

        case (state)
            FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    state_nxt = DECODE;
                end
            end
            DECODE: begin
                state_nxt = legal ? EXEC : HALT;
            end
            EXEC: begin
                if (is_branch) begin
                    state_nxt = FETCH;
                end else if (is_add || is_addi) begin
                    state_nxt = WB;
                end else begin
                    state_nxt = MEM;
                end
            end
            MEM: begin
                mem_req  = 1'b1;
                mem_we   = is_sw;
                mem_addr = result;
                if (mem_ready) begin
                    state_nxt = is_sw ? FETCH : WB;
                end
            end
            WB: begin
                state_nxt = FETCH;
            end
            HALT: begin
                state_nxt = HALT;
            end
            default: begin
                state_nxt = FETCH;
            end
        endcase

        if (rst) begin
            mem_req = 1'b0;
            mem_we  = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc     <= RESET_PC;
            ir     <= '0;
            op_a   <= '0;
            op_b   <= '0;
            imm    <= '0;
            result <= '0;
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                FETCH: begin
                    if (mem_ready) begin
                        ir <= mem_rdata[31:0];
                    end
                end
                DECODE: begin
                    op_a <= rs1_val;
                    op_b <= rs2_val;
                    imm  <= imm_sel;
                end
                EXEC: begin
                    if (is_branch) begin
                        pc <= taken ? (pc + imm) : (pc + WIDTH'(4));
                    end else if (is_add) begin
                        result <= op_a + op_b;
                    end else begin
                        result <= op_a + imm;
                    end
                end
                MEM: begin
                    if (mem_ready) begin
                        if (is_sw) begin
                            pc <= pc + WIDTH'(4);
                        end else begin
                            result <= mem_rdata;
                        end
                    end
                end
                WB: begin
                    if (rd_i != '0) begin
                        regs[rd_i] <= result;
                    end
                    pc <= pc + WIDTH'(4);
                end
                default: begin
                end
            endcase
        end
    end

    assign a0     = regs[RIW'(10)];
    assign halted = (state == HALT);

`ifdef RETIRE_CNT_EN
    // An instruction retires when its final state is left.
    logic retire;

    assign retire = ((state == EXEC) && is_branch)
                 || ((state == MEM) && mem_ready && is_sw)
                 ||  (state == WB);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret <= '0;
        end else if (retire) begin
            instret <= instret + 64'd1;
        end
    end
`endif

endmodule
